jpu_instr_encoder: RTL
======================

# jpu_instr_encoder

Instruction encoder and issue buffer for the JPU front end. It accepts decoded instruction fields (opcode, register selects, flag, immediate) over a valid/ready handshake and packs them into 16-bit JPU instruction words. It queues the words in a small FIFO and presents them one at a time to the Decoder's `instruction`/`enable` inputs, stalling on downstream back-pressure. It is the inverse of the Decoder and is used for program loading, self-test instruction injection, and as the issue stage for generated code.

## Interface
- `DEPTH`, 4, FIFO entries; must be a power of 2 and at least 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous queue clear, e.g. on a branch redirect.
- `in_valid`  in  1  field set on the inputs is valid.
- `in_ready`  out  1  encoder can accept a field set.
- `op`  in  4  ALU opcode.
- `rd`  in  3  destination register select.
- `ra`  in  3  source A register select.
- `rb`  in  3  source B register select.
- `flag`  in  1  instruction flag bit.
- `imm_sel`  in  1  1 = immediate form, 0 = register form.
- `imm`  in  8  immediate data.
- `instruction`  out  16  head-of-queue word; drives the Decoder `instruction` input.
- `enable`  out  1  `instruction` is valid; drives the Decoder `enable` input.
- `out_ready`  in  1  downstream consumes the word this cycle.
- `level`  out  $clog2(DEPTH)+1  number of queued words.

## Operation
- Packing, register form (`imm_sel`=0): {op, rd, flag, ra, rb, 2'b00}.
- Packing, immediate form (`imm_sel`=1): {op, rd, flag, imm}; `ra` and `rb` are ignored.
- Push: on a rising edge where `in_valid && in_ready`, the packed word is written at the write pointer.
- Pop: on a rising edge where `enable && out_ready`, the read pointer advances.
- `in_ready` = !full && !flush. It does not depend on a same-cycle pop, so there is no combinational path from `out_ready` to `in_ready`.
- `enable` = (level != 0), registered-state derived. `instruction` shows the head entry and is 16'h0000 when the queue is empty.
- Simultaneous push and pop: `level` is unchanged and both pointers advance.
- Full: `in_ready`=0. A pop in the same cycle does not allow a push; `in_ready` rises the following cycle.
- Empty with `out_ready`=1: no pop occurs and `enable` stays 0.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is a separate counter running 0..DEPTH.
- Flush: on a rising edge with `flush`=1, pointers and `level` clear. Any same-cycle push or pop is discarded, and the flush takes priority.
- Input fields are don't-care while `in_valid`=0. Field bits must stay stable only in the push cycle.

## Timing
- Reset values: `instruction`=16'h0000, `enable`=0, `in_ready`=1, `level`=0. Pointers are 0 and the FIFO contents are don't-care.
- Reset asserted mid-operation discards all queued words immediately, asynchronously. Outputs take their reset values in the same cycle.
- Push-to-output latency is 1 cycle. A word pushed at edge N shows `enable`=1 after edge N when the queue was empty.
- Throughput is 1 word per cycle when `in_valid` and `out_ready` are held high and the queue is not full.
- Flush: `enable`=0 and `level`=0 after the flush edge. `in_ready`=0 during the flush cycle and 1 on the next cycle.
- Output words are held stable while `enable`=1 and `out_ready`=0.

## Configuration
- `JPU_ENC_BYPASS_EN` defined:
  - When the queue is empty and `in_valid && out_ready && !flush`, the packed word drives `instruction` combinationally with `enable`=1 in the same cycle.
  - The word is consumed without being written and `level` stays 0.
  - In this condition `enable` = `in_valid`, which creates a combinational path from the input fields to the output.
- `JPU_ENC_BYPASS_EN` undefined:
  - There is no bypass; behaviour is exactly as in Operation, with a 1-cycle minimum latency.
  - All outputs are derived only from registered state.

## Test plan
- Packing: push {op=F, rd=1, flag=1, imm_sel=1, imm=42}, {op=3, rd=2, flag=0, ra=0, rb=4, imm_sel=0} and {op=7, rd=4, imm_sel=1, imm=01} with `out_ready`=1 -> `instruction` sequence 16'hF342, 16'h3410, 16'h7801 with `enable`=1, each 1 cycle after its push.
- Fill: `out_ready`=0, push 4 words (DEPTH=4) -> `level`=4 and `in_ready`=0. A 5th `in_valid` is not accepted. Then set `out_ready`=1 -> the 4 words come out in order, `in_ready`=1 after the first pop.
- Concurrent push/pop at `level`=2 for 10 cycles -> `level` stays 2, output order matches input order, and the pointers wrap without loss.
- Flush at `level`=3 with a simultaneous push -> next cycle `level`=0 and `enable`=0, and the pushed word never appears.
- Reset: assert `rst_n`=0 between edges at `level`=2 -> `enable`=0, `instruction`=16'h0000, `level`=0 immediately. After release, the first push appears after 1 cycle.
- With `JPU_ENC_BYPASS_EN`: empty queue, push 16'h3410 with `out_ready`=1 -> `enable`=1 and `instruction`=16'h3410 in the same cycle, and `level` stays 0. Without the macro -> it appears 1 cycle later.

Source files
------------

// File: rtl/jpu_instr_encoder.sv
// JPU instruction encoder: packs decoded fields into 16-bit words and issues them through a small FIFO.
// Optional same-cycle bypass of an empty queue is enabled by defining JPU_ENC_BYPASS_EN.
module jpu_instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               op,
    input  logic [2:0]               rd,
    input  logic [2:0]               ra,
    input  logic [2:0]               rb,
    input  logic                     flag,
    input  logic                     imm_sel,
    input  logic [7:0]               imm,
    output logic [15:0]              instruction,
    output logic                     enable,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic [15:0] packed_word;
    logic        queued_vld;
    logic        full;
    logic        bypass;
    logic        push;
    logic        pop;

    function automatic logic [15:0] pack_word(
        input logic [3:0] f_op,
        input logic [2:0] f_rd,
        input logic [2:0] f_ra,
        input logic [2:0] f_rb,
        input logic       f_flag,
        input logic       f_imm_sel,
        input logic [7:0] f_imm
    );
        if (f_imm_sel) begin
            return {f_op, f_rd, f_flag, f_imm};
        end
        return {f_op, f_rd, f_flag, f_ra, f_rb, 2'b00};
    endfunction

    assign packed_word = pack_word(op, rd, ra, rb, flag, imm_sel, imm);
    assign queued_vld  = (level_q != '0);
    assign full        = (level_q == LW'(DEPTH));

    // in_ready deliberately ignores a same-cycle pop so out_ready never reaches it
    assign in_ready = !full && !flush;

`ifdef JPU_ENC_BYPASS_EN
    assign bypass      = !queued_vld && in_valid && out_ready && !flush;
    assign enable      = queued_vld || bypass;
    assign instruction = queued_vld ? mem_q[rd_ptr_q] : (bypass ? packed_word : 16'h0000);
`else
    assign bypass      = 1'b0;
    assign enable      = queued_vld;
    assign instruction = queued_vld ? mem_q[rd_ptr_q] : 16'h0000;
`endif

    assign level = level_q;
    assign push  = in_valid && in_ready && !bypass;
    assign pop   = queued_vld && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; entries are only observable once level covers them
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= packed_word;
        end
    end

endmodule
